// File: rtl/regfile_pkg.sv
// Shared widths, the XZR index and register typedefs for the multi-port register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 31;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array/busy lookup, XZR masking and, with REGFILE_BYPASS_EN,
// same-cycle forwarding of the write ports.
module regfile_rd_port import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int XZR    = regfile_pkg::ZERO_REG,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [DEPTH-1:0]              busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                          wr0_en,
  input  logic [ADDR_W-1:0]             wr0_addr,
  input  logic [DATA_W-1:0]             wr0_data,
  input  logic                          wr1_en,
  input  logic [ADDR_W-1:0]             wr1_addr,
  input  logic [DATA_W-1:0]             wr1_data,
  input  logic                          mark_en,
  input  logic [ADDR_W-1:0]             mark_addr,
`endif
  output logic [DATA_W-1:0]             rdata,
  output logic                          rbusy
);

  always_comb begin
    rdata = mem[addr];
    rbusy = busy[addr];
`ifdef REGFILE_BYPASS_EN
    // load port outranks ALU port, matching the write arbitration
    if (wr1_en && wr1_addr == addr) begin
      rdata = wr1_data;
      rbusy = mark_en && mark_addr == addr;
    end else if (wr0_en && wr0_addr == addr) begin
      rdata = wr0_data;
      rbusy = mark_en && mark_addr == addr;
    end
`endif
    if (addr == ADDR_W'(XZR)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with XZR and per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;

  // Per-register update: load port wins data conflicts, mark wins over write-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]  <= (i == ZERO_REG) ? '0 : DATA_W'(i);
        busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i != ZERO_REG) begin
          if (wr1_en && wr1_addr == ADDR_W'(i))
            mem[i] <= wr1_data;
          else if (wr0_en && wr0_addr == ADDR_W'(i))
            mem[i] <= wr0_data;

          if (mark_en && mark_addr == ADDR_W'(i))
            busy[i] <= 1'b1;
          else if ((wr1_en && wr1_addr == ADDR_W'(i)) || (wr0_en && wr0_addr == ADDR_W'(i)))
            busy[i] <= 1'b0;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // during reset reads must show init values, so nothing is forwarded
  logic fwd0, fwd1, fwdm;
  assign fwd0 = wr0_en  & ~reset;
  assign fwd1 = wr1_en  & ~reset;
  assign fwdm = mark_en & ~reset;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .XZR    (ZERO_REG),
      .DEPTH  (DEPTH)
    ) u_port (
      .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem       (mem),
      .busy      (busy),
`ifdef REGFILE_BYPASS_EN
      .wr0_en    (fwd0),
      .wr0_addr  (wr0_addr),
      .wr0_data  (wr0_data),
      .wr1_en    (fwd1),
      .wr1_addr  (wr1_addr),
      .wr1_data  (wr1_data),
      .mark_en   (fwdm),
      .mark_addr (mark_addr),
`endif
      .rdata     (rd_data[k*DATA_W +: DATA_W]),
      .rbusy     (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed literal cases plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NRD = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NRD*5-1:0]  rd_addr = '0;
  logic [NRD*64-1:0] rd_data;
  logic [NRD-1:0]  rd_busy;
  logic            wr0_en = 1'b0, wr1_en = 1'b0, mark_en = 1'b0;
  reg_addr_t       wr0_addr = '0, wr1_addr = '0, mark_addr = '0;
  reg_data_t       wr0_data = '0, wr1_data = '0;

  int total = 0;
  int passed = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(NRD), .ZERO_REG(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .mark_en   (mark_en),
    .mark_addr (mark_addr)
  );

  always #5 clk = ~clk;

  // reference model: plain register contents and busy flags
  reg_data_t mdata [32];
  logic      mbusy [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mdata[i] <= (i == 31) ? 64'd0 : 64'(i);
        mbusy[i] <= 1'b0;
      end
    end else begin
      if (wr0_en && wr0_addr != 5'd31) begin
        mdata[wr0_addr] <= wr0_data;
        mbusy[wr0_addr] <= 1'b0;
      end
      if (wr1_en && wr1_addr != 5'd31) begin
        mdata[wr1_addr] <= wr1_data;
        mbusy[wr1_addr] <= 1'b0;
      end
      if (mark_en && mark_addr != 5'd31)
        mbusy[mark_addr] <= 1'b1;
    end
  end

  function automatic reg_data_t exp_data(input reg_addr_t a);
    if (a == 5'd31) return 64'd0;
    if (BYP && !reset && wr1_en && wr1_addr == a) return wr1_data;
    if (BYP && !reset && wr0_en && wr0_addr == a) return wr0_data;
    return mdata[a];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
    if (a == 5'd31) return 1'b0;
    if (BYP && !reset && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)))
      return mark_en && mark_addr == a;
    return mbusy[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // model compare on every falling edge
  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < NRD; k++) begin
        reg_addr_t a;
        a = rd_addr[k*5 +: 5];
        chk($sformatf("model rd_data[%0d] addr %0d", k, a), rd_data[k*64 +: 64], exp_data(a));
        chk($sformatf("model rd_busy[%0d] addr %0d", k, a), {63'd0, rd_busy[k]}, {63'd0, exp_busy(a)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic reg_addr_t raddr();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      4: return 5'd7;
      5: return 5'd9;
      6: return 5'd31;
      7: return 5'd8;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    // reset state, read 5 and 31 while reset is held
    #1 reset = 1'b1;
    rd_addr = {5'd31, 5'd5};
    #2;
    chk("reset rd_data[0]=5", rd_data[63:0], 64'd5);
    chk("reset rd_data[1]=XZR", rd_data[127:64], 64'd0);
    chk("reset rd_busy", {62'd0, rd_busy}, 64'd0);
    tick();
    reset = 1'b0;
    run_cmp = 1'b1;

    // write to reg 3, same-cycle and next-cycle read
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'hDEAD_BEEF;
    rd_addr = {5'd31, 5'd3};
    #1 chk("same-cycle read reg3", rd_data[63:0], BYP ? 64'hDEAD_BEEF : 64'd3);
    tick();
    wr0_en = 1'b0;
    #1 chk("next-cycle read reg3", rd_data[63:0], 64'hDEAD_BEEF);

    // write conflict on reg 7
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h22;
    rd_addr = {5'd9, 5'd7};
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    #1 chk("conflict reg7 load wins", rd_data[63:0], 64'h22);

    // scoreboard on reg 9
    mark_en = 1'b1; mark_addr = 5'd9;
    #1 chk("mark same cycle busy9", {63'd0, rd_busy[1]}, 64'd0);
    tick();
    mark_en = 1'b0;
    #1 chk("busy9 after mark", {63'd0, rd_busy[1]}, 64'd1);
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h55;
    #1 chk("busy9 during wr1", {63'd0, rd_busy[1]}, BYP ? 64'd0 : 64'd1);
    tick();
    wr1_en = 1'b0;
    #1 chk("busy9 cleared", {63'd0, rd_busy[1]}, 64'd0);
    mark_en = 1'b1; mark_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h66;
    tick();
    mark_en = 1'b0; wr0_en = 1'b0;
    #1 chk("mark+wr0 busy9 stays", {63'd0, rd_busy[1]}, 64'd1);
    chk("mark+wr0 data9", rd_data[127:64], 64'h66);

    // XZR write and mark are ignored
    wr0_en = 1'b1; wr0_addr = 5'd31; wr0_data = 64'hFF;
    mark_en = 1'b1; mark_addr = 5'd31;
    rd_addr = {5'd9, 5'd31};
    tick();
    wr0_en = 1'b0; mark_en = 1'b0;
    #1 chk("XZR data", rd_data[63:0], 64'd0);
    chk("XZR busy", {63'd0, rd_busy[0]}, 64'd0);

    // async reset between edges after write+mark on reg 4
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 64'hAA;
    tick();
    wr0_en = 1'b0;
    mark_en = 1'b1; mark_addr = 5'd4;
    tick();
    mark_en = 1'b0;
    rd_addr = {5'd9, 5'd4};
    #1 chk("reg4 before reset", rd_data[63:0], 64'hAA);
    chk("busy4 before reset", {63'd0, rd_busy[0]}, 64'd1);
    reset = 1'b1;
    #1 chk("reg4 async reset", rd_data[63:0], 64'd4);
    chk("busy4 async reset", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    reset = 1'b0;

    // randomized traffic with occasional mid-cycle reset pulses
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 149) == 0);
      wr0_en    = $urandom_range(0, 1) == 1;
      wr0_addr  = raddr();
      wr0_data  = {$urandom, $urandom};
      wr1_en    = $urandom_range(0, 2) == 0;
      wr1_addr  = raddr();
      wr1_data  = {$urandom, $urandom};
      mark_en   = $urandom_range(0, 2) == 0;
      mark_addr = raddr();
      rd_addr   = {raddr(), raddr()};
      tick();
    end
    reset = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; mark_en = 1'b0;
    tick();
    tick();
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle 32x64 register file for the ARMLEG datapath.
- Clocked write ports, NUM_RD combinational read ports, hardwired zero register (XZR), and a per-register busy scoreboard.
- Sits between decode (reads, busy marking) and writeback (ALU port 0, load port 1); lets the pipelined core detect RAW hazards.

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 31, index hardwired to zero (XZR)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing
- rd_busy  out  NUM_RD  busy flag of the register addressed by each read port
- wr0_en  in  1  ALU writeback enable
- wr0_addr  in  ADDR_W  ALU writeback address
- wr0_data  in  DATA_W  ALU writeback data
- wr1_en  in  1  load writeback enable
- wr1_addr  in  ADDR_W  load writeback address
- wr1_data  in  DATA_W  load writeback data
- mark_en  in  1  decode issue: set busy on mark_addr
- mark_addr  in  ADDR_W  destination of the issued instruction

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset:
  - Register i loads the value i, zero-extended to DATA_W; ZERO_REG loads 0.
  - All busy bits clear.
  - During reset, rd_data returns those init values combinationally; rd_busy = 0.
- Reads:
  - Combinational from the array and busy bits; zero-cycle latency.
  - rd_addr == ZERO_REG always returns 0 and busy 0.
- Writes:
  - Committed on rising clk; visible on rd_data from the next cycle (without bypass).
  - A write whose address is ZERO_REG is discarded.
- Write conflict: wr0_en and wr1_en to the same address in one cycle -> wr1_data stored (load port wins). No error flag.
- Scoreboard, evaluated per register each cycle:
  - mark_en on reg r -> busy[r] <= 1.
  - Any wr0/wr1 write to r -> busy[r] <= 0.
  - Mark and write to the same r in one cycle -> mark wins; busy stays 1 and the data is still stored.
  - mark_en to ZERO_REG is ignored.
  - A write to a non-busy register is legal; busy stays 0.
- Reset asserted mid-operation: array and busy bits return to init values immediately, independent of clk; in-flight writes are lost.
- No X propagation: out-of-range addresses cannot occur, since depth = 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - rd_addr matching an enabled write address in the same cycle returns that write's data combinationally.
  - wr1 takes priority over wr0; ZERO_REG still reads 0.
  - rd_busy for that port returns 0, unless mark_en targets the same register in that cycle.
- Undefined: reads return pre-edge array contents and pre-edge busy; the new value appears the next cycle.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, ZERO_REG constant, reg_addr_t and reg_data_t typedefs.
- Sub-module regfile_rd_port: one read port, covering zero-register masking, the optional bypass mux and the busy lookup. Instantiated NUM_RD times via generate.
- Array, write arbitration and scoreboard stay in regfile_mp.

Test Plan:
- Reset, then read ports at addresses 5 and 31 -> rd_data = 5 and 0; rd_busy = 00.
- wr0 to reg 3 with 0xDEAD_BEEF, read reg 3 the same cycle -> old value 3 (bypass off) or 0xDEAD_BEEF (bypass on); next cycle 0xDEAD_BEEF in both builds.
- wr0 (0x11) and wr1 (0x22) both to reg 7 in one cycle -> reg 7 reads 0x22.
- mark_en to reg 9 -> rd_busy = 1 on the next cycle; wr1 to reg 9 -> busy clears the following cycle; mark and wr0 to reg 9 in the same cycle -> busy stays 1, data updated.
- wr0 with 0xFF to reg 31 and mark_en to reg 31 -> reg 31 reads 0, busy 0.
- Write 0xAA to reg 4, mark reg 4, assert reset between clock edges -> reg 4 reads 4 and busy is 0 immediately, before the next clk edge.
